// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: memory-op encodings,
// exception codes, reset PC, stage state and the latched payload layout.
package mem_stage_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h1c000000;

   localparam logic [3:0] MEM_OP_NONE = 4'b0000;
   localparam logic [3:0] MEM_OP_LD_B  = 4'b1000;
   localparam logic [3:0] MEM_OP_LD_H  = 4'b1001;
   localparam logic [3:0] MEM_OP_LD_W  = 4'b1010;
   localparam logic [3:0] MEM_OP_LD_BU = 4'b1100;
   localparam logic [3:0] MEM_OP_LD_HU = 4'b1101;
   localparam logic [3:0] MEM_OP_ST_B  = 4'b0001;
   localparam logic [3:0] MEM_OP_ST_H  = 4'b0010;
   localparam logic [3:0] MEM_OP_ST_W  = 4'b0011;

   localparam logic [5:0] ECODE_SYS = 6'h0B;
   localparam logic [5:0] ECODE_ALE = 6'h09;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } ms_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] addr;
      logic [3:0]  rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic [3:0]  csr_we;
      logic [13:0] csr_num;
      logic [31:0] csr_wdata;
      logic        ertn;
      logic        syscall;
      logic        ale;
   } ms_payload_t;

   // Misalignment rule: halfword ops need addr[0]=0, word ops need addr[1:0]=0.
   // Byte ops, "none" and unassigned codes never fault.
   function automatic logic ale_of(input logic [3:0] mem_op, input logic [1:0] addr_lo);
      logic ale;
      ale = 1'b0;
      case (mem_op)
         MEM_OP_LD_H, MEM_OP_LD_HU, MEM_OP_ST_H: ale = addr_lo[0];
         MEM_OP_LD_W, MEM_OP_ST_W:               ale = |addr_lo;
         MEM_OP_LD_B, MEM_OP_LD_BU, MEM_OP_ST_B,
         MEM_OP_NONE:                            ale = 1'b0;
         default:                                ale = 1'b0;
      endcase
      return ale;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-memory stage bus: valid-qualified instruction payload forward,
// allow_in back. The execute side is the master.
interface mem_stage_if;
   logic        es_to_ms_valid;
   logic        ms_allow_in;
   logic [31:0] es_pc;
   logic [3:0]  es_mem_op;
   logic [31:0] es_sram_addr;
   logic [3:0]  es_rf_we;
   logic [4:0]  es_rf_waddr;
   logic [31:0] es_rf_wdata;
   logic [3:0]  es_csr_we;
   logic [13:0] es_csr_num;
   logic [31:0] es_csr_wdata;
   logic        es_ertn;
   logic        es_syscall;
   logic [14:0] es_syscall_code;

   modport master (
      output es_to_ms_valid, es_pc, es_mem_op, es_sram_addr, es_rf_we, es_rf_waddr,
             es_rf_wdata, es_csr_we, es_csr_num, es_csr_wdata, es_ertn, es_syscall,
             es_syscall_code,
      input  ms_allow_in
   );

   // The syscall code is not needed to commit SYS (its subcode is always 0),
   // so the memory stage does not listen to it.
   modport slave (
      input  es_to_ms_valid, es_pc, es_mem_op, es_sram_addr, es_rf_we, es_rf_waddr,
             es_rf_wdata, es_csr_we, es_csr_num, es_csr_wdata, es_ertn, es_syscall,
      output ms_allow_in
   );
endinterface

// File: rtl/mem_stage_ale_check.sv
// Address-misalignment detector: memory op plus low address bits to ALE flag.
module mem_stage_ale_check
   import mem_stage_pkg::*;
(
   input  logic [3:0] mem_op,
   input  logic [1:0] addr_lo,
   output logic       ale
);

   assign ale = ale_of(mem_op, addr_lo);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one-entry valid-qualified payload register, ALE detect,
// precise exception / ERTN commit pulses with flush, and forwarding bus.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   mem_stage_if.slave      es_bus,
   input  logic            ws_allow_in,
   output logic            ms_to_ws_valid,
   output logic [31:0]     ms_pc,
   output logic [3:0]      ms_rf_we,
   output logic [4:0]      ms_rf_waddr,
   output logic [31:0]     ms_rf_wdata,
   output logic [3:0]      ms_csr_we,
   output logic [13:0]     ms_csr_num,
   output logic [31:0]     ms_csr_wdata,
   output logic            fwd_valid,
   output logic [4:0]      fwd_waddr,
   output logic [31:0]     fwd_wdata,
   output logic            ex_valid,
   output logic [5:0]      ex_ecode,
   output logic [8:0]      ex_esubcode,
   output logic [31:0]     ex_pc,
   output logic [31:0]     ex_badv,
   output logic            ertn_valid,
   output logic            ex_flush
);

   localparam ms_payload_t PAYLOAD_RST = '{pc: PC_RESET, default: '0};

   ms_state_e   state_reg, state_next;
   ms_payload_t payload_reg, payload_next;

   logic ms_valid;
   logic ms_allow_in;
   logic exc;
   logic kill;
   logic leave;
   logic es_ale;

   mem_stage_ale_check u_ale_check (
      .mem_op  (es_bus.es_mem_op),
      .addr_lo (es_bus.es_sram_addr[1:0]),
      .ale     (es_ale)
   );

   assign ms_valid    = (state_reg == ST_FULL);
   assign ms_allow_in = !ms_valid || ws_allow_in;
   assign exc         = payload_reg.ale || payload_reg.syscall;
   assign kill        = exc || payload_reg.ertn;
   assign leave       = ms_valid && ws_allow_in;
   assign ex_valid    = leave && exc;
   assign ertn_valid  = leave && payload_reg.ertn;
   assign ex_flush    = ex_valid || ertn_valid;

   assign es_bus.ms_allow_in = ms_allow_in;

   // State register and payload capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_EMPTY;
         payload_reg <= PAYLOAD_RST;
      end else begin
         state_reg   <= state_next;
         payload_reg <= payload_next;
      end
   end

   // Next state: a commit flush empties the stage and drops the arriving
   // instruction; otherwise accept whenever allowed, holding payload when idle.
   always_comb begin
      state_next   = state_reg;
      payload_next = payload_reg;
      if (ex_flush) begin
         state_next = ST_EMPTY;
      end else if (ms_allow_in) begin
         if (es_bus.es_to_ms_valid) begin
            state_next             = ST_FULL;
            payload_next.pc        = es_bus.es_pc;
            payload_next.addr      = es_bus.es_sram_addr;
            payload_next.rf_we     = es_bus.es_rf_we;
            payload_next.rf_waddr  = es_bus.es_rf_waddr;
            payload_next.rf_wdata  = es_bus.es_rf_wdata;
            payload_next.csr_we    = es_bus.es_csr_we;
            payload_next.csr_num   = es_bus.es_csr_num;
            payload_next.csr_wdata = es_bus.es_csr_wdata;
            payload_next.ertn      = es_bus.es_ertn;
            payload_next.syscall   = es_bus.es_syscall;
            payload_next.ale       = es_ale;
         end else begin
            state_next = ST_EMPTY;
         end
      end
   end

   // Payload outputs; an excepting or ERTN instruction must not write GPRs/CSRs
   // but still travels to write-back so the slot retires.
   always_comb begin
      ms_to_ws_valid = ms_valid;
      ms_pc          = payload_reg.pc;
      ms_rf_waddr    = payload_reg.rf_waddr;
      ms_rf_wdata    = payload_reg.rf_wdata;
      ms_csr_num     = payload_reg.csr_num;
      ms_csr_wdata   = payload_reg.csr_wdata;
      ms_rf_we       = payload_reg.rf_we;
      ms_csr_we      = payload_reg.csr_we;
      if (ms_valid && kill) begin
         ms_rf_we  = 4'd0;
         ms_csr_we = 4'd0;
      end
      fwd_valid = ms_valid && (|payload_reg.rf_we) && !kill;
      fwd_waddr = payload_reg.rf_waddr;
      fwd_wdata = payload_reg.rf_wdata;
   end

   // Exception fields, held at zero outside the commit pulse; ALE outranks SYS.
   always_comb begin
      ex_ecode    = 6'd0;
      ex_esubcode = 9'd0;
      ex_pc       = 32'd0;
      ex_badv     = 32'd0;
      if (ex_valid) begin
         ex_ecode = payload_reg.ale ? ECODE_ALE : ECODE_SYS;
         ex_pc    = payload_reg.pc;
         ex_badv  = payload_reg.ale ? payload_reg.addr : 32'd0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam logic [31:0] PC_RST = 32'h1c000000;

   logic        clk;
   logic        reset;
   logic        ws_allow_in;
   logic        ms_to_ws_valid;
   logic [31:0] ms_pc;
   logic [3:0]  ms_rf_we;
   logic [4:0]  ms_rf_waddr;
   logic [31:0] ms_rf_wdata;
   logic [3:0]  ms_csr_we;
   logic [13:0] ms_csr_num;
   logic [31:0] ms_csr_wdata;
   logic        fwd_valid;
   logic [4:0]  fwd_waddr;
   logic [31:0] fwd_wdata;
   logic        ex_valid;
   logic [5:0]  ex_ecode;
   logic [8:0]  ex_esubcode;
   logic [31:0] ex_pc;
   logic [31:0] ex_badv;
   logic        ertn_valid;
   logic        ex_flush;

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage_if es_bus ();

   mem_stage #(.PC_RESET(PC_RST)) dut (
      .clk            (clk),
      .reset          (reset),
      .es_bus         (es_bus),
      .ws_allow_in    (ws_allow_in),
      .ms_to_ws_valid (ms_to_ws_valid),
      .ms_pc          (ms_pc),
      .ms_rf_we       (ms_rf_we),
      .ms_rf_waddr    (ms_rf_waddr),
      .ms_rf_wdata    (ms_rf_wdata),
      .ms_csr_we      (ms_csr_we),
      .ms_csr_num     (ms_csr_num),
      .ms_csr_wdata   (ms_csr_wdata),
      .fwd_valid      (fwd_valid),
      .fwd_waddr      (fwd_waddr),
      .fwd_wdata      (fwd_wdata),
      .ex_valid       (ex_valid),
      .ex_ecode       (ex_ecode),
      .ex_esubcode    (ex_esubcode),
      .ex_pc          (ex_pc),
      .ex_badv        (ex_badv),
      .ertn_valid     (ertn_valid),
      .ex_flush       (ex_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic [3:0] op, input logic [31:0] addr,
                       input logic [3:0] rf_we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic ertn, input logic syscall);
      es_bus.es_to_ms_valid  = 1'b1;
      es_bus.es_pc           = pc;
      es_bus.es_mem_op       = op;
      es_bus.es_sram_addr    = addr;
      es_bus.es_rf_we        = rf_we;
      es_bus.es_rf_waddr     = waddr;
      es_bus.es_rf_wdata     = wdata;
      es_bus.es_csr_we       = 4'h0;
      es_bus.es_csr_num      = 14'h0;
      es_bus.es_csr_wdata    = 32'h0;
      es_bus.es_ertn         = ertn;
      es_bus.es_syscall      = syscall;
      es_bus.es_syscall_code = 15'h0;
      $display("txn pc=%h op=%b addr=%h rf_we=%h ertn=%0d syscall=%0d ws_allow_in=%0d",
               pc, op, addr, rf_we, ertn, syscall, ws_allow_in);
   endtask

   task automatic idle();
      es_bus.es_to_ms_valid = 1'b0;
   endtask

   logic [3:0]  tbl_op   [6];
   logic [31:0] tbl_addr [6];
   logic        tbl_ale  [6];

   initial begin
      tbl_op[0] = MEM_OP_LD_HU; tbl_addr[0] = 32'h0000_0002; tbl_ale[0] = 1'b0;
      tbl_op[1] = MEM_OP_LD_B;  tbl_addr[1] = 32'h0000_0003; tbl_ale[1] = 1'b0;
      tbl_op[2] = MEM_OP_ST_H;  tbl_addr[2] = 32'h0000_0001; tbl_ale[2] = 1'b1;
      tbl_op[3] = MEM_OP_LD_W;  tbl_addr[3] = 32'h0000_0002; tbl_ale[3] = 1'b1;
      tbl_op[4] = MEM_OP_ST_B;  tbl_addr[4] = 32'h0000_0001; tbl_ale[4] = 1'b0;
      tbl_op[5] = MEM_OP_NONE;  tbl_addr[5] = 32'h0000_0003; tbl_ale[5] = 1'b0;

      reset       = 1'b1;
      ws_allow_in = 1'b1;
      send(32'h0, MEM_OP_NONE, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b0);
      idle();
      tick();
      tick();

      // Reset state.
      check("rst_allow_in", {31'd0, es_bus.ms_allow_in}, 32'd1);
      check("rst_valid",    {31'd0, ms_to_ws_valid}, 32'd0);
      check("rst_pc",       ms_pc, PC_RST);
      check("rst_rf_we",    {28'd0, ms_rf_we}, 32'd0);
      check("rst_fwd",      {31'd0, fwd_valid}, 32'd0);
      check("rst_ex",       {31'd0, ex_valid}, 32'd0);
      check("rst_ex_pc",    ex_pc, 32'd0);
      check("rst_flush",    {31'd0, ex_flush}, 32'd0);
      reset = 1'b0;
      tick();

      // Aligned ld.w passes through in one cycle and forwards.
      send(32'h1c001000, MEM_OP_LD_W, 32'h1c001004, 4'hf, 5'd5, 32'hdeadbeef, 1'b0, 1'b0);
      tick();
      check("ldw_valid",  {31'd0, ms_to_ws_valid}, 32'd1);
      check("ldw_pc",     ms_pc, 32'h1c001000);
      check("ldw_rf_we",  {28'd0, ms_rf_we}, 32'h0000000f);
      check("ldw_fwd",    {31'd0, fwd_valid}, 32'd1);
      check("ldw_fwd_a",  {27'd0, fwd_waddr}, 32'd5);
      check("ldw_fwd_d",  fwd_wdata, 32'hdeadbeef);
      check("ldw_ex",     {31'd0, ex_valid}, 32'd0);
      idle();
      tick();
      check("ldw_drain",  {31'd0, ms_to_ws_valid}, 32'd0);

      // Misaligned ld.h: ALE pulse, suppressed writes, and a discarded follower.
      send(32'h1c000010, MEM_OP_LD_H, 32'h00000003, 4'hf, 5'd7, 32'h12345678, 1'b0, 1'b0);
      tick();
      check("ldh_ex",     {31'd0, ex_valid}, 32'd1);
      check("ldh_ecode",  {26'd0, ex_ecode}, 32'h09);
      check("ldh_badv",   ex_badv, 32'h00000003);
      check("ldh_ex_pc",  ex_pc, 32'h1c000010);
      check("ldh_rf_we",  {28'd0, ms_rf_we}, 32'd0);
      check("ldh_fwd",    {31'd0, fwd_valid}, 32'd0);
      check("ldh_flush",  {31'd0, ex_flush}, 32'd1);
      check("ldh_wsv",    {31'd0, ms_to_ws_valid}, 32'd1);
      send(32'h1c000014, MEM_OP_LD_W, 32'h00000000, 4'hf, 5'd8, 32'h1, 1'b0, 1'b0);
      tick();
      check("ldh_after_v",  {31'd0, ms_to_ws_valid}, 32'd0);
      check("ldh_after_ex", {31'd0, ex_valid}, 32'd0);
      idle();
      tick();

      // Stalled syscall: no pulse while write-back is blocked, then exactly one.
      ws_allow_in = 1'b0;
      send(32'h1c000020, MEM_OP_NONE, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1);
      tick();
      send(32'h1c000024, MEM_OP_LD_W, 32'h0, 4'hf, 5'd9, 32'h2, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("sys_stall_ex",    {31'd0, ex_valid}, 32'd0);
         check("sys_stall_allow", {31'd0, es_bus.ms_allow_in}, 32'd0);
         check("sys_stall_pc",    ms_pc, 32'h1c000020);
         tick();
      end
      idle();
      ws_allow_in = 1'b1;
      #1;
      check("sys_ex",     {31'd0, ex_valid}, 32'd1);
      check("sys_ecode",  {26'd0, ex_ecode}, 32'h0B);
      check("sys_ex_pc",  ex_pc, 32'h1c000020);
      check("sys_badv",   ex_badv, 32'd0);
      check("sys_subc",   {23'd0, ex_esubcode}, 32'd0);
      tick();
      check("sys_once",   {31'd0, ex_valid}, 32'd0);
      check("sys_empty",  {31'd0, ms_to_ws_valid}, 32'd0);

      // ERTN commit drops the instruction arriving in the same cycle.
      send(32'h1c000030, MEM_OP_NONE, 32'h0, 4'h0, 5'd0, 32'h0, 1'b1, 1'b0);
      tick();
      check("ertn_pulse", {31'd0, ertn_valid}, 32'd1);
      check("ertn_noex",  {31'd0, ex_valid}, 32'd0);
      check("ertn_flush", {31'd0, ex_flush}, 32'd1);
      send(32'h1c000040, MEM_OP_LD_W, 32'h0, 4'hf, 5'd3, 32'h3, 1'b0, 1'b0);
      tick();
      check("ertn_drop_v",  {31'd0, ms_to_ws_valid}, 32'd0);
      check("ertn_drop_pc", ms_pc, 32'h1c000030);
      check("ertn_once",    {31'd0, ertn_valid}, 32'd0);
      idle();
      tick();

      // ALE outranks SYSCALL.
      send(32'h1c000050, MEM_OP_ST_W, 32'h00000002, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1);
      tick();
      check("prio_ex",    {31'd0, ex_valid}, 32'd1);
      check("prio_ecode", {26'd0, ex_ecode}, 32'h09);
      check("prio_badv",  ex_badv, 32'h00000002);
      idle();
      tick();

      // Alignment boundary table.
      for (int k = 0; k < 6; k++) begin
         send(32'h1c000100 + 32'(k * 4), tbl_op[k], tbl_addr[k], 4'h0, 5'd0, 32'h0, 1'b0, 1'b0);
         tick();
         check($sformatf("ale_tbl%0d", k), {31'd0, ex_valid}, {31'd0, tbl_ale[k]});
         idle();
         tick();
      end

      // Reset while FULL and stalled clears the stage and drops the pulse.
      ws_allow_in = 1'b0;
      send(32'h1c000060, MEM_OP_NONE, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1);
      tick();
      idle();
      check("rstst_full", {31'd0, ms_to_ws_valid}, 32'd1);
      reset = 1'b1;
      tick();
      check("rstst_valid", {31'd0, ms_to_ws_valid}, 32'd0);
      check("rstst_pc",    ms_pc, PC_RST);
      check("rstst_allow", {31'd0, es_bus.ms_allow_in}, 32'd1);
      ws_allow_in = 1'b1;
      #1;
      check("rstst_ex",    {31'd0, ex_valid}, 32'd0);
      check("rstst_flush", {31'd0, ex_flush}, 32'd0);
      reset = 1'b0;
      tick();
      check("rstst_after", {31'd0, ex_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and write-back. Holds one instruction in a valid-qualified payload register under the valid/allow_in handshake and detects address-misalignment (ALE). It commits precise exceptions (SYSCALL, ALE) and ERTN as one-cycle pulses that flush all younger stages, and drives the MEM-stage forwarding bus for the decode stage.

## Interface
Parameters:
- PC_RESET, 32'h1c000000, reset value of ms_pc.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- es_to_ms_valid  in  1  execute stage has a finished instruction (es_valid && es_ready_go)
- ms_allow_in  out  1  stage can accept this cycle
- es_pc  in  32  instruction PC
- es_mem_op  in  4  memory op code; 0 = none
- es_sram_addr  in  32  effective address
- es_rf_we  in  4  register write enable
- es_rf_waddr  in  5  destination register
- es_rf_wdata  in  32  result (already load-extended)
- es_csr_we  in  4  CSR write enable
- es_csr_num  in  14  CSR number
- es_csr_wdata  in  32  CSR write data
- es_ertn  in  1  instruction is ERTN
- es_syscall  in  1  instruction is SYSCALL
- es_syscall_code  in  15  SYSCALL code
- ws_allow_in  in  1  write-back can accept
- ms_to_ws_valid  out  1  valid instruction leaving to write-back
- ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata, ms_csr_we, ms_csr_num, ms_csr_wdata  out  32/4/5/32/4/14/32  registered payload
- fwd_valid  out  1  forwarding bus valid
- fwd_waddr  out  5  forwarding destination
- fwd_wdata  out  32  forwarding data
- ex_valid  out  1  exception commit pulse
- ex_ecode  out  6  0x0B SYS, 0x09 ALE
- ex_esubcode  out  9  always 0
- ex_pc  out  32  faulting PC (ERA)
- ex_badv  out  32  BADV; faulting address for ALE, else 0
- ertn_valid  out  1  ERTN commit pulse
- ex_flush  out  1  ex_valid || ertn_valid

## Operation
- mem_op encoding: 1000 ld.b, 1001 ld.h, 1010 ld.w, 1100 ld.bu, 1101 ld.hu, 0001 st.b, 0010 st.h, 0011 st.w.
- ALE rules: h-ops require addr[0]=0. w-ops require addr[1:0]=00. b-ops and 0000 never fault.
- Exception priority: ALE > SYSCALL. ERTN is never combined with an exception.
- Two states: EMPTY (ms_valid=0) and FULL (ms_valid=1). ms_ready_go is always 1.
- ms_allow_in = !ms_valid || ws_allow_in.
- Capture: on ms_allow_in && es_to_ms_valid, latch the payload and compute/latch the ALE flag, then ms_valid<=1. On ms_allow_in without valid input, ms_valid<=0 and the payload holds.
- leave = ms_valid && ws_allow_in.
- ex_valid = leave && (ale || syscall). ertn_valid = leave && ertn.
- While ms_valid and the instruction carries an exception or ERTN, ms_rf_we=0, ms_csr_we=0 and fwd_valid=0 are forced. ms_to_ws_valid stays 1 so write-back retires the slot.
- ex_flush is high: on the next edge ms_valid<=0 regardless of es_to_ms_valid, and the incoming instruction is discarded.
- fwd_valid = ms_valid && |ms_rf_we && !exc. fwd_waddr/fwd_wdata mirror the payload.
- ex_* fields are combinational from the payload and are only meaningful while ex_valid.

## Timing
- Latency: 1 cycle, es input to ms outputs.
- Reset values: ms_valid=0, ms_pc=PC_RESET, all other payload 0. Every output is therefore 0 except ms_allow_in=1 and ms_pc=PC_RESET.
- Stall: when ws_allow_in=0 and FULL, the payload is frozen, ms_allow_in=0 and no pulse is produced. The pulse fires in the first cycle ws_allow_in=1: exactly one cycle per excepting instruction.
- Simultaneous flush and capture: flush wins and the stage becomes EMPTY.
- Reset mid-stall clears valid and drops any pending pulse.

## Structure
- Shared package: mem_op encodings, ECODE_SYS/ECODE_ALE, PC_RESET, payload struct.
- Optional sub-module ale_check: combinational, mem_op + addr[1:0] → ale.

## Test plan
- ld.w at 0x1c001004, ws_allow_in=1 → ms_to_ws_valid 1 cycle later, fwd_valid=1, no ex_valid.
- ld.h at addr 0x00000003 → ex_valid=1 for 1 cycle, ecode=0x09, badv=0x00000003, ms_rf_we=0, ex_flush=1, next cycle ms_valid=0.
- syscall at pc 0x1c000020 with ws_allow_in low 3 cycles → no pulse, ms_allow_in=0; then single pulse with ecode=0x0B, ex_pc=0x1c000020.
- ertn with a valid instruction arriving in the same cycle → ertn_valid=1, arriving instruction dropped, ms_valid=0 afterwards.
- st.w at 0x2 with syscall=1 → ecode=0x09 (ALE priority).
- Reset asserted while FULL and stalled → all outputs at reset values next cycle, no pulse.
